// File: rtl/musa_loader_pkg.sv
// Shared types and constants for the MUSA instruction-memory loader.
package musa_loader_pkg;

    localparam int MUSA_WORD_W     = 32;
    localparam int MUSA_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/musa_imem_loader_if.sv
// Upstream word stream plus instruction-memory write port of the loader.
interface musa_imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic                                   in_valid;
    logic [musa_loader_pkg::MUSA_WORD_W-1:0] in_data;
    logic                                   in_ready;
    logic [musa_loader_pkg::MUSA_WORD_W-1:0] write_data;
    logic [ADDR_W-1:0]                      adr_write;
    logic                                   write_en;

    // Host/bench side: produces the stream, observes the memory writes.
    modport master (
        output in_valid, in_data,
        input  in_ready, write_data, adr_write, write_en
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, write_data, adr_write, write_en
    );
endinterface

// File: rtl/musa_loader_csum.sv
// Running mod-2^32 sum of loaded words with equality compare; used only
// when MUSA_LOADER_CHECKSUM_EN is defined.
module musa_loader_csum
    import musa_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   add_en,
    input  logic [MUSA_WORD_W-1:0] add_val,
    input  logic [MUSA_WORD_W-1:0] cmp_val,
    output logic                   match
);
    logic [MUSA_WORD_W-1:0] sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        sum_q <= '0;
        else if (clr)    sum_q <= '0;
        else if (add_en) sum_q <= sum_q + add_val;
    end

    assign match = (sum_q == cmp_val);
endmodule

// File: rtl/musa_imem_loader.sv
// Streams instruction words into imem, then releases the core via cpu_run.
// Optional checksum word after the data: define MUSA_LOADER_CHECKSUM_EN.
module musa_imem_loader
    import musa_loader_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [$clog2(DEPTH):0]   load_len,
    musa_imem_loader_if.slave        bus,
    output logic                     busy,
    output logic                     cpu_run,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   words_loaded
);
    localparam int LEN_W = $clog2(DEPTH) + 1;

    loader_state_t     state, state_nxt;
    logic [LEN_W-1:0]  len_q, words_q, sel_len;
    logic [ADDR_W-1:0] ptr_q;
    logic              restart_q;
    logic              restart, start_req, go_load;
    logic              load_done, in_ready_c, accept, load_acc;

    // A start seen in RUN/ERR parks in IDLE for one cycle so cpu_run/err
    // drop, then replays the latched length as if started from IDLE.
    assign restart   = load_start && (state == ST_RUN || state == ST_ERR);
    assign start_req = (state == ST_IDLE) && (load_start || restart_q);
    assign sel_len   = restart_q ? len_q : load_len;
    assign load_done = (words_q == len_q);
    assign go_load   = start_req && (state_nxt == ST_LOAD);

`ifdef MUSA_LOADER_CHECKSUM_EN
    logic csum_match;
    assign in_ready_c = (state == ST_LOAD && !load_done) || (state == ST_CHECK);

    musa_loader_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .clr     (go_load),
        .add_en  (load_acc),
        .add_val (bus.in_data),
        .cmp_val (bus.in_data),
        .match   (csum_match)
    );
`else
    // Gating on !load_done holds off the cycle after the last word, which
    // keeps cpu_run from overlapping the final write_en.
    assign in_ready_c = (state == ST_LOAD) && !load_done;
`endif

    assign accept   = bus.in_valid && in_ready_c;
    assign load_acc = accept && (state == ST_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    if (sel_len == '0)                 state_nxt = ST_RUN;
                    else if (sel_len > LEN_W'(DEPTH))  state_nxt = ST_ERR;
                    else                               state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
`ifdef MUSA_LOADER_CHECKSUM_EN
                if (load_done) state_nxt = ST_CHECK;
`else
                if (load_done) state_nxt = ST_RUN;
`endif
            end
`ifdef MUSA_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) state_nxt = csum_match ? ST_RUN : ST_ERR;
            end
`endif
            ST_RUN, ST_ERR: begin
                if (load_start) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q          <= '0;
            words_q        <= '0;
            ptr_q          <= BASE_ADDR;
            restart_q      <= 1'b0;
            bus.write_en   <= 1'b0;
            bus.write_data <= '0;
            bus.adr_write  <= '0;
        end else begin
            restart_q    <= restart;
            bus.write_en <= load_acc;
            if (restart)      len_q <= load_len;
            else if (go_load) len_q <= sel_len;
            if (go_load) begin
                words_q <= '0;
                ptr_q   <= BASE_ADDR;
            end else if (load_acc) begin
                words_q <= words_q + 1'b1;
                ptr_q   <= ptr_q + ADDR_W'(MUSA_WORD_BYTES);
            end
            if (load_acc) begin
                bus.write_data <= bus.in_data;
                bus.adr_write  <= ptr_q;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign busy          = (state == ST_LOAD) || (state == ST_CHECK);
    assign cpu_run       = (state == ST_RUN);
    assign err           = (state == ST_ERR);
    assign words_loaded  = words_q;
endmodule

// File: tb/tb_musa_imem_loader.sv
// Scoreboard bench for musa_imem_loader: expected writes are queued by the
// stimulus and retired by a write monitor.
module tb_musa_imem_loader;
    import musa_loader_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int LEN_W  = $clog2(DEPTH) + 1;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_start = 1'b0;
    logic [LEN_W-1:0] load_len = '0;
    logic             busy, cpu_run, err;
    logic [LEN_W-1:0] words_loaded;

    musa_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    musa_imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_len     (load_len),
        .bus          (bus),
        .busy         (busy),
        .cpu_run      (cpu_run),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;
    logic [31:0] csum;
    int          w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every observed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && bus.write_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                         bus.adr_write, bus.write_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", bus.adr_write, mon_e.addr);
                chk("wr_data", bus.write_data, mon_e.data);
            end
            chk("run_during_write", cpu_run, 1'b0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int len);
        load_len   = LEN_W'(len);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        exp_addr   = BASE;
        csum       = 32'h0;
    endtask

    task automatic send(input logic [31:0] d, output int waits);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        waits = 0;
        while (!bus.in_ready && waits < 20) begin
            tick();
            waits++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 after %0d cycles, required 1", waits);
        end else begin
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] d, output int waits);
        exp_q.push_back('{addr: exp_addr, data: d});
        exp_addr = exp_addr + 32'd4;
        csum     = csum + d;
        send(d, waits);
        chk("wr_latency", bus.write_en, 1'b1);
    endtask

    task automatic finish_load();
        int fw;
`ifdef MUSA_LOADER_CHECKSUM_EN
        send(csum, fw);
        bus.in_valid = 1'b0;
        chk("run_after_csum", cpu_run, 1'b1);
        chk("csum_no_write", bus.write_en, 1'b0);
`else
        fw = 0;
        bus.in_valid = 1'b0;
        chk("run_low_at_last_write", cpu_run, 1'b0 + 1'(fw));
        tick();
        chk("run_after_last", cpu_run, 1'b1);
`endif
    endtask

    logic [31:0] t1_words [3] = '{32'h3C01_1001, 32'h3421_0004, 32'h8C22_0000};
    logic [31:0] t2_words [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        exp_addr     = BASE;
        csum         = 32'h0;

        // Reset values
        #12;
        chk("rst_cpu_run", cpu_run, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_write_en", bus.write_en, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_words", words_loaded, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 3-word load, in_valid held high, including during the start cycle
        chk("idle_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        start(3);
        chk("t1_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_word(t1_words[i], w);
            chk("t1_no_stall", w, 0);
        end
        finish_load();
        chk("t1_words", words_loaded, 3);
        chk("t1_busy_done", busy, 1'b0);

        // 4-word load with in_valid toggling, restarted from RUN
        start(4);
        chk("t2_run_drop", cpu_run, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                bus.in_valid = 1'b0;
                tick();
            end
            send_word(t2_words[i], w);
        end
        finish_load();
        chk("t2_words", words_loaded, 4);

        // Reload of a single word from RUN
        start(1);
        chk("t6_run_drop", cpu_run, 1'b0);
        send_word(32'hA5A5_0001, w);
        finish_load();
        chk("t6_words", words_loaded, 1);

        // Reset after 2 of 5 words
        start(5);
        send_word(32'h0000_00AA, w);
        send_word(32'h0000_00BB, w);
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", bus.in_ready, 1'b0);
        chk("mid_rst_write_en", bus.write_en, 1'b0);
        chk("mid_rst_words", words_loaded, 0);
        chk("mid_rst_adr", bus.adr_write, 0);
        chk("mid_rst_data", bus.write_data, 0);
        chk("mid_rst_run", cpu_run, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_pending", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        chk("post_rst_in_ready", bus.in_ready, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        tick();
        tick();
        bus.in_valid = 1'b0;

        // Overlong length from IDLE
        start(DEPTH + 1);
        chk("ovf_err", err, 1'b1);
        chk("ovf_run", cpu_run, 1'b0);
        chk("ovf_busy", busy, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("ovf_err_sticky", err, 1'b1);
        start(2);
        chk("ovf_err_clear", err, 1'b0);
        send_word(32'h0000_1234, w);
        send_word(32'h0000_5678, w);
        finish_load();
        chk("ovf_reload_words", words_loaded, 2);

`ifdef MUSA_LOADER_CHECKSUM_EN
        // Bad checksum: no write of the checksum word, core held off
        start(3);
        send_word(32'd1, w);
        send_word(32'd2, w);
        send_word(32'd3, w);
        chk("csum_model", csum, 32'd6);
        send(32'd7, w);
        bus.in_valid = 1'b0;
        chk("csum_bad_err", err, 1'b1);
        chk("csum_bad_run", cpu_run, 1'b0);
        tick();
        chk("csum_bad_run_hold", cpu_run, 1'b0);
        // Good checksum (6) after the failed session
        start(3);
        send_word(32'd1, w);
        send_word(32'd2, w);
        send_word(32'd3, w);
        finish_load();
        chk("csum_good_err", err, 1'b0);
`endif

        tick();
        tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
